// File: rtl/mdu_hilo.sv
// ----------------------------------------------------------------------------
// mdu_hilo -- EX-stage multiply/divide unit owning the architectural HI/LO.
//
// Accepts mult/multu/div/divu (and madd when MDU_MADD_EN is defined) on a
// start pulse. The result is computed into staged registers at issue. It is
// committed to HI/LO on the last busy cycle's edge, so busy stays high for
// exactly MULT_CYCLES / DIV_CYCLES cycles. mthi/mtlo write HI/LO on the issue
// edge without raising busy. A start while busy is ignored.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> op 7 accumulates the signed product into {HI,LO}. The
//                accumulator is read at commit time, not at issue time.
//   undefined -> op 7 behaves as op 0 (no-op).
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   issue pulse, qualifies mlu_op/a/b
//   mlu_op   in   5   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd
//   mlu_out  in   3   read select: 1 HI, 2 LO, else 0
//   a, b     in  32   rs / rt operands
//   busy     out  1   operation in flight
//   res      out 32   committed HI/LO selected by mlu_out (combinational)
//   hi, lo   out 32   architectural HI/LO
// ----------------------------------------------------------------------------
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  mlu_op,
    input  logic [2:0]  mlu_out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] res,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MTHI  = 5'd5;
    localparam logic [4:0] OP_MTLO  = 5'd6;
    localparam logic [4:0] OP_MADD  = 5'd7;

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        done;
    logic        idle;
    logic        is_mul_op, is_div_op, accept;
    logic [31:0] hi_n, lo_n;
    logic        dz_q;

    assign idle = (state == S_IDLE);
    assign busy = !idle;

    // ---------------- operation decode ----------------
    always_comb begin
        is_div_op = (mlu_op == OP_DIV) || (mlu_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_mul_op = (mlu_op == OP_MULT) || (mlu_op == OP_MULTU) || (mlu_op == OP_MADD);
`else
        is_mul_op = (mlu_op == OP_MULT) || (mlu_op == OP_MULTU);
`endif
        accept = start && idle && (is_mul_op || is_div_op);
    end

    // ---------------- datapath ----------------
    // One 64x64 multiplier serves signed and unsigned forms: the operands are
    // sign- or zero-extended to 64 bits and the low 64 product bits are kept.
    logic        mul_sx;
    logic [63:0] mul_a, mul_b, prod;

    always_comb begin
        mul_sx = (mlu_op == OP_MULT) || (mlu_op == OP_MADD);
        mul_a  = {{32{mul_sx & a[31]}}, a};
        mul_b  = {{32{mul_sx & b[31]}}, b};
        prod   = mul_a * mul_b;
    end

    // Signed division runs on magnitudes through the unsigned divider, then
    // fixes signs: quotient negative iff signs differ, remainder follows the
    // dividend. 0x80000000 / -1 therefore yields 0x80000000 rem 0 without
    // any special case. A zero divisor is replaced by 1 only to keep the
    // divider defined; the result is discarded at commit.
    logic        div_sg, a_neg, b_neg;
    logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

    always_comb begin
        div_sg = (mlu_op == OP_DIV);
        a_neg  = div_sg & a[31];
        b_neg  = div_sg & b[31];
        mag_a  = a_neg ? (32'd0 - a) : a;
        mag_b  = b_neg ? (32'd0 - b) : b;
        if (mag_b == 32'd0) mag_b = 32'd1;
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        quo    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem    = a_neg ? (32'd0 - ur) : ur;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_div_op ? S_DIV : S_MUL;
                    cnt_d   = is_div_op ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == 4'd0) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- staged result / HI-LO ----------------
`ifdef MDU_MADD_EN
    logic madd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_n   <= 32'd0;
            lo_n   <= 32'd0;
            dz_q   <= 1'b0;
`ifdef MDU_MADD_EN
            madd_q <= 1'b0;
`endif
        end else if (accept) begin
            {hi_n, lo_n} <= is_div_op ? {rem, quo} : prod;
            dz_q         <= is_div_op && (b == 32'd0);
`ifdef MDU_MADD_EN
            madd_q       <= (mlu_op == OP_MADD);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (done) begin
            if (!dz_q) begin
`ifdef MDU_MADD_EN
                if (madd_q) {hi, lo} <= {hi, lo} + {hi_n, lo_n};
                else        {hi, lo} <= {hi_n, lo_n};
`else
                {hi, lo} <= {hi_n, lo_n};
`endif
            end
        end else if (start && idle) begin
            if (mlu_op == OP_MTHI) hi <= a;
            if (mlu_op == OP_MTLO) lo <= a;
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        case (mlu_out)
            3'd1:    res = hi;
            3'd2:    res = lo;
            default: res = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// ----------------------------------------------------------------------------
// tb_mdu_hilo -- randomized self-checking bench for mdu_hilo.
// Reference model uses native SV arithmetic on HI/LO and a per-op cycle count.
// ----------------------------------------------------------------------------
module tb_mdu_hilo;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  mlu_op = 5'd0;
    logic [2:0]  mlu_out = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy;
    logic [31:0] res, hi, lo;

    mdu_hilo #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mlu_op(mlu_op),
        .mlu_out(mlu_out), .a(a), .b(b), .busy(busy), .res(res),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: updates m_hi/m_lo and returns the expected busy cycle count.
    task automatic model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int cyc);
        longint          ps;
        longint unsigned pu;
        int              q, r;
        cyc = 0;
        ps  = longint'($signed(x)) * longint'($signed(y));
        pu  = {32'd0, x} * {32'd0, y};
        case (op)
            5'd1: begin {m_hi, m_lo} = ps; cyc = MULT_CYCLES; end
            5'd2: begin {m_hi, m_lo} = pu; cyc = MULT_CYCLES; end
            5'd3: begin
                cyc = DIV_CYCLES;
                if (y == 0) ;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    m_lo = q; m_hi = r;
                end
            end
            5'd4: begin
                cyc = DIV_CYCLES;
                if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            end
            5'd5: m_hi = x;
            5'd6: m_lo = x;
`ifdef MDU_MADD_EN
            5'd7: begin {m_hi, m_lo} = {m_hi, m_lo} + ps; cyc = MULT_CYCLES; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op, optionally poke a second start mid-flight, count busy
    // cycles, then compare HI/LO and the read port against the model.
    task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit poke);
        int exp_cyc, n;
        model(op, x, y, exp_cyc);
        @(negedge clk);
        start = 1'b1; mlu_op = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd0; a = $urandom; b = $urandom;
        n = 0;
        while (busy && n < 64) begin
            if (poke && n == 1) begin
                start = 1'b1; mlu_op = 5'($urandom_range(1, 7));
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk($sformatf("busy_cycles op%0d", op), n, exp_cyc);
        chk($sformatf("hi op%0d", op), hi, m_hi);
        chk($sformatf("lo op%0d", op), lo, m_lo);
        mlu_out = 3'd1; #1 chk("res_hi", res, m_hi);
        mlu_out = 3'd2; #1 chk("res_lo", res, m_lo);
        mlu_out = 3'($urandom_range(3, 7)); #1 chk("res_zero", res, 32'd0);
        mlu_out = 3'd0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        // Reset state
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Reset mid-op: preload HI/LO, start mult 3*4, reset two cycles in
        do_op(5'd5, 32'hAAAA, 32'd0, 1'b0);
        do_op(5'd6, 32'h5555, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; mlu_op = 5'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd0);

        // Directed cases
        do_op(5'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("smul_hi_const", hi, 32'hFFFF_FFFF);
        chk("smul_lo_const", lo, 32'hFFFF_FFFA);
        do_op(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("umul_hi_const", hi, 32'hFFFF_FFFE);
        chk("umul_lo_const", lo, 32'h0000_0001);
        do_op(5'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("sdiv_lo_const", lo, 32'hFFFF_FFFD);
        chk("sdiv_hi_const", hi, 32'hFFFF_FFFF);
        do_op(5'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);
        chk("div0_lo_const", lo, 32'hFFFF_FFFD);
        chk("div0_hi_const", hi, 32'hFFFF_FFFF);
        do_op(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_const", lo, 32'h8000_0000);
        chk("ovf_hi_const", hi, 32'd0);
        do_op(5'd5, 32'h1234, 32'd0, 1'b0);
        chk("mthi_const", hi, 32'h1234);
        do_op(5'd0, 32'hDEAD, 32'hBEEF, 1'b0);
        do_op(5'd4, 32'd100, 32'd7, 1'b1);   // second start during busy

        // madd: HI=0, LO=FFFFFFFF, then +1*1
        do_op(5'd5, 32'd0, 32'd0, 1'b0);
        do_op(5'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(5'd7, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_hi_const", hi, 32'd1);
        chk("madd_lo_const", lo, 32'd0);
`else
        chk("madd_hi_const", hi, 32'd0);
        chk("madd_lo_const", lo, 32'hFFFF_FFFF);
`endif

        // Random ops
        for (int i = 0; i < 300; i++)
            do_op(5'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 4) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
